fetch_align: RTL and testbench

//  Fetch-to-buffer alignment stage; sits between the I-cache fill/read path and inst_buf.
//  - Accepts one 8-instruction (256-bit) fetch line per handshake.
//  - Masks slots that lie before the fetch entry point.
//  - Holds lines in a small skid FIFO while the instruction buffer reports full.
//  - Presents one aligned bundle per cycle as inst0..7 + per-slot valid bits.

---
 rtl/fetch_align.sv | 141 ++++++++++++++
 tb/tb_fetch_align.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Fetch-to-buffer alignment stage: masks pre-entry slots, holds lines in a skid FIFO
// while inst_buf is full, and issues one aligned bundle per cycle. Option: FETCH_ALIGN_CTI_TRUNC_EN.
module fetch_align #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            line_vld_i,
  output logic            line_rdy_o,
  input  logic [255:0]    line_i,
  input  logic [PC_W-1:0] line_pc_i,
  input  logic            buf_full_i,
  output logic [31:0]     inst0_o,
  output logic [31:0]     inst1_o,
  output logic [31:0]     inst2_o,
  output logic [31:0]     inst3_o,
  output logic [31:0]     inst4_o,
  output logic [31:0]     inst5_o,
  output logic [31:0]     inst6_o,
  output logic [31:0]     inst7_o,
  output logic            inst0_vld_o,
  output logic            inst1_vld_o,
  output logic            inst2_vld_o,
  output logic            inst3_vld_o,
  output logic            inst4_vld_o,
  output logic            inst5_vld_o,
  output logic            inst6_vld_o,
  output logic            inst7_vld_o,
  output logic [PC_W-1:0] bundle_pc_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [255:0]    data_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [7:0]      mask_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic push, issue, pop;
  logic [7:0] push_mask;

  logic [255:0]    head_data;
  logic [PC_W-1:0] head_pc;
  logic [7:0]      head_mask;
  logic [7:0]      slot_vld;
  logic [31:0]     slot_inst [8];

  // Ready depends only on registered occupancy, never on buf_full_i.
  assign line_rdy_o = (count_reg < CNT_W'(DEPTH));
  assign push       = line_vld_i & line_rdy_o & ~flush_i;
  assign issue      = (count_reg != '0) & ~buf_full_i & ~flush_i;
  assign pop        = issue;

  // Entry mask, optionally truncated after the first valid control transfer.
  always_comb begin
    logic [7:0] pos_mask;
    logic       seen_cti;
    logic [5:0] opcode;
    pos_mask  = '0;
    seen_cti  = 1'b0;
    opcode    = '0;
    push_mask = '0;
    for (int k = 0; k < 8; k++) begin
      pos_mask[k] = (3'(k) >= line_pc_i[4:2]);
    end
`ifdef FETCH_ALIGN_CTI_TRUNC_EN
    for (int k = 0; k < 8; k++) begin
      opcode       = line_i[32*k+26 +: 6];
      push_mask[k] = pos_mask[k] & ~seen_cti;
      if (pos_mask[k] && ((opcode[5:4] == 2'b11) || (opcode == 6'h1A))) begin
        seen_cti = 1'b1;
      end
    end
`else
    push_mask = pos_mask;
`endif
  end

  // Storage carries no reset; contents are only observed through a nonzero count.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= line_i;
      pc_mem[wr_ptr_reg]   <= line_pc_i;
      mask_mem[wr_ptr_reg] <= push_mask;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data   = data_mem[rd_ptr_reg];
  assign head_pc     = pc_mem[rd_ptr_reg];
  assign head_mask   = mask_mem[rd_ptr_reg];
  assign bundle_pc_o = issue ? head_pc : '0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    assign slot_vld[gi]  = issue & head_mask[gi];
    assign slot_inst[gi] = slot_vld[gi] ? head_data[32*gi +: 32] : 32'h0;
  end

  assign inst0_o = slot_inst[0];
  assign inst1_o = slot_inst[1];
  assign inst2_o = slot_inst[2];
  assign inst3_o = slot_inst[3];
  assign inst4_o = slot_inst[4];
  assign inst5_o = slot_inst[5];
  assign inst6_o = slot_inst[6];
  assign inst7_o = slot_inst[7];

  assign inst0_vld_o = slot_vld[0];
  assign inst1_vld_o = slot_vld[1];
  assign inst2_vld_o = slot_vld[2];
  assign inst3_vld_o = slot_vld[3];
  assign inst4_vld_o = slot_vld[4];
  assign inst5_vld_o = slot_vld[5];
  assign inst6_vld_o = slot_vld[6];
  assign inst7_vld_o = slot_vld[7];

endmodule

// File: tb/tb_fetch_align.sv
// Directed self-checking bench for fetch_align (default DEPTH=2, PC_W=64).
module tb_fetch_align;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush_i;
  logic         line_vld_i;
  logic         line_rdy_o;
  logic [255:0] line_i;
  logic [63:0]  line_pc_i;
  logic         buf_full_i;
  logic [31:0]  inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o;
  logic         inst0_vld_o, inst1_vld_o, inst2_vld_o, inst3_vld_o;
  logic         inst4_vld_o, inst5_vld_o, inst6_vld_o, inst7_vld_o;
  logic [63:0]  bundle_pc_o;
  logic [7:0]   vld;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign vld = {inst7_vld_o, inst6_vld_o, inst5_vld_o, inst4_vld_o,
                inst3_vld_o, inst2_vld_o, inst1_vld_o, inst0_vld_o};

  fetch_align dut (
    .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
    .line_vld_i(line_vld_i), .line_rdy_o(line_rdy_o), .line_i(line_i),
    .line_pc_i(line_pc_i), .buf_full_i(buf_full_i),
    .inst0_o(inst0_o), .inst1_o(inst1_o), .inst2_o(inst2_o), .inst3_o(inst3_o),
    .inst4_o(inst4_o), .inst5_o(inst5_o), .inst6_o(inst6_o), .inst7_o(inst7_o),
    .inst0_vld_o(inst0_vld_o), .inst1_vld_o(inst1_vld_o),
    .inst2_vld_o(inst2_vld_o), .inst3_vld_o(inst3_vld_o),
    .inst4_vld_o(inst4_vld_o), .inst5_vld_o(inst5_vld_o),
    .inst6_vld_o(inst6_vld_o), .inst7_vld_o(inst7_vld_o),
    .bundle_pc_o(bundle_pc_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic present(input logic [255:0] l, input logic [63:0] pc);
    line_vld_i = 1'b1;
    line_i     = l;
    line_pc_i  = pc;
  endtask

  task automatic idle_line();
    line_vld_i = 1'b0;
    line_i     = '0;
    line_pc_i  = '0;
  endtask

  logic [255:0] cti_line;

  initial begin
    reset_n    = 1'b0;
    flush_i    = 1'b0;
    buf_full_i = 1'b0;
    idle_line();

    // 1: reset state, then a full line from slot 0
    sample();
    check("rst_rdy", 64'(line_rdy_o), 64'h1);
    check("rst_vld", 64'(vld), 64'h0);
    check("rst_pc", bundle_pc_o, 64'h0);
    next_cycle();
    reset_n = 1'b1;
    present(make_line(32'h1000_0000), 64'h100);
    sample();
    check("t1_latency_vld", 64'(vld), 64'h0);
    next_cycle();
    idle_line();
    sample();
    check("t1_vld", 64'(vld), 64'hFF);
    check("t1_inst3", 64'(inst3_o), 64'h1000_0003);
    check("t1_pc", bundle_pc_o, 64'h100);

    // 2: entry at slot 5
    next_cycle();
    present(make_line(32'h2000_0000), 64'h14);
    next_cycle();
    idle_line();
    sample();
    check("t2_vld", 64'(vld), 64'hE0);
    check("t2_inst0", 64'(inst0_o), 64'h0);
    check("t2_inst4", 64'(inst4_o), 64'h0);
    check("t2_inst5", 64'(inst5_o), 64'h2000_0005);
    check("t2_pc", bundle_pc_o, 64'h14);
    next_cycle();
    sample();
    check("t2_empty_vld", 64'(vld), 64'h0);

    // 3: fill under stall, third line waits, drain in order
    next_cycle();
    buf_full_i = 1'b1;
    present(make_line(32'h3000_0000), 64'h200);
    sample();
    check("t3_rdy_a", 64'(line_rdy_o), 64'h1);
    next_cycle();
    present(make_line(32'h3100_0000), 64'h220);
    sample();
    check("t3_stall_vld", 64'(vld), 64'h0);
    check("t3_rdy_b", 64'(line_rdy_o), 64'h1);
    next_cycle();
    present(make_line(32'h3200_0000), 64'h248);
    sample();
    check("t3_rdy_full", 64'(line_rdy_o), 64'h0);
    check("t3_stall_pc", bundle_pc_o, 64'h0);
    next_cycle();
    buf_full_i = 1'b0;
    sample();
    check("t3_issue_a_pc", bundle_pc_o, 64'h200);
    check("t3_issue_a_inst0", 64'(inst0_o), 64'h3000_0000);
    check("t3_rdy_still_full", 64'(line_rdy_o), 64'h0);
    next_cycle();
    sample();
    check("t3_issue_b_pc", bundle_pc_o, 64'h220);
    check("t3_issue_b_inst7", 64'(inst7_o), 64'h3100_0007);
    check("t3_rdy_c", 64'(line_rdy_o), 64'h1);
    next_cycle();
    idle_line();
    sample();
    check("t3_issue_c_pc", bundle_pc_o, 64'h248);
    check("t3_issue_c_vld", 64'(vld), 64'hFC);
    next_cycle();
    sample();
    check("t3_drained_vld", 64'(vld), 64'h0);

    // 4: flush with two held lines and an incoming line
    buf_full_i = 1'b1;
    present(make_line(32'h4000_0000), 64'h300);
    next_cycle();
    present(make_line(32'h4100_0000), 64'h320);
    next_cycle();
    buf_full_i = 1'b0;
    flush_i    = 1'b1;
    present(make_line(32'h4200_0000), 64'h340);
    sample();
    check("t4_flush_vld", 64'(vld), 64'h0);
    check("t4_flush_pc", bundle_pc_o, 64'h0);
    next_cycle();
    flush_i = 1'b0;
    idle_line();
    sample();
    check("t4_post_rdy", 64'(line_rdy_o), 64'h1);
    check("t4_post_vld", 64'(vld), 64'h0);
    // flush with room available must still refuse the incoming line
    next_cycle();
    flush_i = 1'b1;
    present(make_line(32'h4300_0000), 64'h360);
    next_cycle();
    flush_i = 1'b0;
    idle_line();
    sample();
    check("t4_no_push_vld", 64'(vld), 64'h0);
    check("t4_no_push_pc", bundle_pc_o, 64'h0);

    // 5: branch in slot 2, entry slot 0
    next_cycle();
    cti_line = make_line(32'h0000_0000);
    cti_line[64 +: 32] = 32'hE000_0010;
    present(cti_line, 64'h0);
    next_cycle();
    idle_line();
    sample();
`ifdef FETCH_ALIGN_CTI_TRUNC_EN
    check("t5_cti_vld", 64'(vld), 64'h07);
`else
    check("t5_cti_vld", 64'(vld), 64'hFF);
`endif
    check("t5_inst2", 64'(inst2_o), 64'hE000_0010);
    // jump before the entry point is ignored; branch in slot 5 truncates
    next_cycle();
    cti_line = make_line(32'h0000_0000);
    cti_line[32 +: 32]  = 32'h6800_0000;
    cti_line[160 +: 32] = 32'hE000_0000;
    present(cti_line, 64'h0C);
    next_cycle();
    idle_line();
    sample();
`ifdef FETCH_ALIGN_CTI_TRUNC_EN
    check("t5_entry_cti_vld", 64'(vld), 64'h38);
`else
    check("t5_entry_cti_vld", 64'(vld), 64'hF8);
`endif

    // 6: asynchronous reset mid-stall with two held lines
    next_cycle();
    buf_full_i = 1'b1;
    present(make_line(32'h6000_0000), 64'h600);
    next_cycle();
    present(make_line(32'h6100_0000), 64'h620);
    next_cycle();
    idle_line();
    #1;
    check("t6_full_before_rst", 64'(line_rdy_o), 64'h0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_rdy", 64'(line_rdy_o), 64'h1);
    check("t6_rst_vld", 64'(vld), 64'h0);
    next_cycle();
    reset_n    = 1'b1;
    buf_full_i = 1'b0;
    sample();
    check("t6_after_vld", 64'(vld), 64'h0);
    check("t6_after_pc", bundle_pc_o, 64'h0);
    next_cycle();
    sample();
    check("t6_after2_vld", 64'(vld), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
